// File: rtl/clkctrl_sched.sv
// Sequencer for the PHI2 clock switch: turns a level fast/slow request into one
// handshaked switch at a time, with dwell, timeout and glitch-free divider updates.
module clkctrl_sched #(
   parameter int SYNC_STAGES    = 2,
   parameter int DWELL_CYCLES   = 8,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CW             = 8
) (
   input  logic          hsclk_in,
   input  logic          rst,
   input  logic          fast_req,
   input  logic [1:0]    div_sel_in,
   input  logic          div_wr,
   input  logic          hsclk_selected,
   input  logic          lsclk_selected,
   output logic          hsclk_sel,
   output logic [1:0]    cpuclk_div_sel,
   output logic          sw_busy,
   output logic          sw_timeout,
   output logic [CW-1:0] sw_count,
   output logic [1:0]    state_dbg
);

   localparam logic [1:0] LS_RUN = 2'd0;
   localparam logic [1:0] TO_HS  = 2'd1;
   localparam logic [1:0] HS_RUN = 2'd2;
   localparam logic [1:0] TO_LS  = 2'd3;

   localparam logic [CW-1:0] DWELL_INIT = CW'(DWELL_CYCLES);
   localparam logic [CW-1:0] TMO_INIT   = CW'(TIMEOUT_CYCLES);

   logic [SYNC_STAGES-1:0] hs_sync_q, hs_sync_d;
   logic [SYNC_STAGES-1:0] ls_sync_q, ls_sync_d;
   logic [1:0]             state_q, state_d;
   logic                   hsclk_sel_q, hsclk_sel_d;
   logic [1:0]             div_q, div_d;
   logic [1:0]             pend_q, pend_d;
   logic [CW-1:0]          dwell_q, dwell_d;
   logic [CW-1:0]          tmo_q, tmo_d;
   logic                   timeout_q, timeout_d;
   logic [CW-1:0]          count_q, count_d;
   logic [CW-1:0]          count_inc;
   logic                   hs_s, ls_s;
   logic                   dwell_done;

   always_comb begin
      hs_sync_d = {hs_sync_q[SYNC_STAGES-2:0], hsclk_selected};
      ls_sync_d = {ls_sync_q[SYNC_STAGES-2:0], lsclk_selected};
   end

   assign hs_s = hs_sync_q[SYNC_STAGES-1];
   assign ls_s = ls_sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d     = state_q;
      hsclk_sel_d = hsclk_sel_q;
      dwell_d     = dwell_q;
      tmo_d       = tmo_q;
      timeout_d   = timeout_q;
      count_d     = count_q;
      dwell_done  = (dwell_q == '0);
      count_inc   = (count_q == '1) ? count_q : count_q + CW'(1);

      if ((state_q == LS_RUN || state_q == HS_RUN) && !dwell_done)
         dwell_d = dwell_q - CW'(1);

      case (state_q)
         LS_RUN: begin
            if (fast_req && dwell_done) begin
               state_d     = TO_HS;
               hsclk_sel_d = 1'b1;
               tmo_d       = TMO_INIT;
            end
         end
         TO_HS: begin
            if (hs_s && !ls_s) begin
               state_d = HS_RUN;
               count_d = count_inc;
               dwell_d = DWELL_INIT;
            end else if (tmo_q == '0) begin
               // Fast clock never confirmed: fall back to slow and report it.
               state_d     = TO_LS;
               timeout_d   = 1'b1;
               hsclk_sel_d = 1'b0;
               tmo_d       = TMO_INIT;
            end else begin
               tmo_d = tmo_q - CW'(1);
            end
         end
         HS_RUN: begin
            if (!fast_req && dwell_done) begin
               state_d     = TO_LS;
               hsclk_sel_d = 1'b0;
               tmo_d       = TMO_INIT;
            end
         end
         TO_LS: begin
            if (ls_s && !hs_s) begin
               state_d = LS_RUN;
               count_d = count_inc;
               dwell_d = DWELL_INIT;
            end else if (tmo_q == '0) begin
               timeout_d = 1'b1;
            end else begin
               tmo_d = tmo_q - CW'(1);
            end
         end
      endcase
   end

   // Divider only moves while on the slow clock; a same-edge write applies next edge.
   always_comb begin
      pend_d = div_wr ? div_sel_in : pend_q;
      div_d  = (state_q == LS_RUN && pend_q != div_q) ? pend_q : div_q;
   end

   always_ff @(posedge hsclk_in) begin
      if (rst) begin
         hs_sync_q   <= '0;
         ls_sync_q   <= '0;
         state_q     <= LS_RUN;
         hsclk_sel_q <= 1'b0;
         div_q       <= 2'b00;
         pend_q      <= 2'b00;
         dwell_q     <= DWELL_INIT;
         tmo_q       <= TMO_INIT;
         timeout_q   <= 1'b0;
         count_q     <= '0;
      end else begin
         hs_sync_q   <= hs_sync_d;
         ls_sync_q   <= ls_sync_d;
         state_q     <= state_d;
         hsclk_sel_q <= hsclk_sel_d;
         div_q       <= div_d;
         pend_q      <= pend_d;
         dwell_q     <= dwell_d;
         tmo_q       <= tmo_d;
         timeout_q   <= timeout_d;
         count_q     <= count_d;
      end
   end

   assign hsclk_sel      = hsclk_sel_q;
   assign cpuclk_div_sel = div_q;
   assign sw_busy        = (state_q == TO_HS) || (state_q == TO_LS);
   assign sw_timeout     = timeout_q;
   assign sw_count       = count_q;
   assign state_dbg      = state_q;

endmodule
